aemb_gprf_mt: RTL and testbench

//  Next-generation general-purpose register file for the aeMB decode/writeback boundary.

---
 rtl/aemb_gprf_mt_if.sv | 39 +++
 rtl/aemb_gprf_mt.sv | 133 +++++++++++++
 tb/tb_aemb_gprf_mt.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aemb_gprf_mt_if.sv
// Decode/writeback bundle for the aeMB multithreaded register file.
// The master side is the pipeline; the slave side is the register file.
interface aemb_gprf_mt_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 1
);
  logic          gena;
  logic [TW-1:0] d_tid;
  logic [AW-1:0] d_ra;
  logic [AW-1:0] d_rb;
  logic [AW-1:0] d_rd;
  logic [DW-1:0] d_da;
  logic [DW-1:0] d_db;
  logic [DW-1:0] d_dd;
  logic [TW-1:0] w_tid;
  logic [AW-1:0] w_rw;
  logic          w_wre;
  logic [1:0]    w_sel;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_lnk;
  logic [DW-1:0] m_dat;
  logic [3:0]    m_sel;
  logic          m_sgn;
  logic          g_rdy;
  logic          g_err;

  modport master (
    output gena, d_tid, d_ra, d_rb, d_rd,
    output w_tid, w_rw, w_wre, w_sel, w_alu, w_lnk, m_dat, m_sel, m_sgn,
    input  d_da, d_db, d_dd, g_rdy, g_err
  );

  modport slave (
    input  gena, d_tid, d_ra, d_rb, d_rd,
    input  w_tid, w_rw, w_wre, w_sel, w_alu, w_lnk, m_dat, m_sel, m_sgn,
    output d_da, d_db, d_dd, g_rdy, g_err
  );
endinterface

// File: rtl/aemb_gprf_mt.sv
// Banked aeMB register file: three bypassed async read ports, writeback mux with
// load sizer, and a post-reset sweep that zeroes the unreset storage array.
module aemb_gprf_mt #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned TW = 1
) (
  input logic            gclk,
  input logic            grst,
  aemb_gprf_mt_if.slave  bus
);
  localparam int unsigned IW = AW + TW;
  localparam int unsigned NE = 2 ** IW;

  typedef enum logic {CLR, RUN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic          rdy_q;
  logic          err_q, err_nxt;

  logic [DW-1:0] mem [NE];

  logic [7:0]    lane3, lane2, lane1, lane0, lane_b;
  logic [15:0]   half_h;
  logic          sel_legal_c;
  logic          src_legal_c;
  logic [DW-1:0] ld_val_c;
  logic [DW-1:0] wdat_c;
  logic          commit_c;
  logic          we_c;
  logic [IW-1:0] waddr_c;
  logic [DW-1:0] wval_c;

  // Byte lanes are taken from the top 32 bits so wider words keep aeMB lane numbering.
  assign lane3 = bus.m_dat[DW-1  -: 8];
  assign lane2 = bus.m_dat[DW-9  -: 8];
  assign lane1 = bus.m_dat[DW-17 -: 8];
  assign lane0 = bus.m_dat[DW-25 -: 8];

  // Load sizer and legality of the byte-lane select.
  always_comb begin
    sel_legal_c = 1'b1;
    lane_b      = lane0;
    half_h      = {lane1, lane0};
    ld_val_c    = bus.m_dat;
    unique case (bus.m_sel)
      4'h8: lane_b = lane3;
      4'h4: lane_b = lane2;
      4'h2: lane_b = lane1;
      4'h1: lane_b = lane0;
      4'hC: half_h = {lane3, lane2};
      4'h3: half_h = {lane1, lane0};
      4'hF, 4'h0: ;
      default: sel_legal_c = 1'b0;
    endcase
    if (bus.m_sel == 4'h8 || bus.m_sel == 4'h4 || bus.m_sel == 4'h2 || bus.m_sel == 4'h1)
      ld_val_c = bus.m_sgn ? {{(DW-8){lane_b[7]}}, lane_b} : {{(DW-8){1'b0}}, lane_b};
    else if (bus.m_sel == 4'hC || bus.m_sel == 4'h3)
      ld_val_c = bus.m_sgn ? {{(DW-16){half_h[15]}}, half_h} : {{(DW-16){1'b0}}, half_h};
  end

  // Writeback source mux.
  always_comb begin
    src_legal_c = 1'b1;
    wdat_c      = '0;
    unique case (bus.w_sel)
      2'b00: wdat_c = bus.w_alu;
      2'b01: begin
        wdat_c      = ld_val_c;
        src_legal_c = sel_legal_c;
      end
      2'b10: wdat_c = bus.w_lnk;
      default: src_legal_c = 1'b0;
    endcase
  end

  assign commit_c = (state == RUN) & bus.w_wre & bus.gena & src_legal_c;

  // During the sweep the counter owns the single write port.
  assign we_c    = (state == CLR) | (commit_c & (bus.w_rw != '0));
  assign waddr_c = (state == CLR) ? cnt : {bus.w_tid, bus.w_rw};
  assign wval_c  = (state == CLR) ? '0 : wdat_c;

  always_ff @(posedge gclk) begin
    if (we_c) mem[waddr_c] <= wval_c;
  end

  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    if (state == CLR)
      return '0;
    if (commit_c && (bus.w_tid == bus.d_tid) && (bus.w_rw == a) && (a != '0))
      return wdat_c;
    return mem[{bus.d_tid, a}];
  endfunction

  assign bus.d_da  = rd_port(bus.d_ra);
  assign bus.d_db  = rd_port(bus.d_rb);
  assign bus.d_dd  = rd_port(bus.d_rd);
  assign bus.g_rdy = rdy_q;
  assign bus.g_err = err_q;

  // Sweep / run sequencing and sticky error.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    unique case (state)
      CLR: begin
        cnt_nxt = cnt + IW'(1);
        if (cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (bus.w_wre && bus.gena && !src_legal_c) err_nxt = 1'b1;
      end
      default: state_nxt = CLR;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state <= CLR;
      cnt   <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy_q <= (state_nxt == RUN);
      err_q <= err_nxt;
    end
  end
endmodule

// File: tb/tb_aemb_gprf_mt.sv
// Directed bench for aemb_gprf_mt with a behavioural register-file model checked
// on every falling edge, plus literal expectations for the key scenarios.
module tb_aemb_gprf_mt;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned TW = 1;
  localparam int NREG = 32;
  localparam int NENT = 64;

  logic gclk = 1'b0;
  logic grst = 1'b1;

  aemb_gprf_mt_if #(.DW(DW), .AW(AW), .TW(TW)) b ();

  aemb_gprf_mt #(.DW(DW), .AW(AW), .TW(TW)) dut (
    .gclk (gclk),
    .grst (grst),
    .bus  (b.slave)
  );

  always #5 gclk = ~gclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mdl [2][NREG];
  int          sweep;
  bit          merr;

  function automatic logic [31:0] load_val();
    logic [7:0]  by;
    logic [15:0] hw;
    int lane;
    lane = -1;
    case (b.m_sel)
      4'h8: lane = 3;
      4'h4: lane = 2;
      4'h2: lane = 1;
      4'h1: lane = 0;
      default: lane = -1;
    endcase
    if (lane >= 0) begin
      by = 8'(b.m_dat >> (8 * lane));
      return b.m_sgn ? 32'($signed(by)) : 32'(by);
    end
    if (b.m_sel == 4'hC || b.m_sel == 4'h3) begin
      hw = (b.m_sel == 4'hC) ? 16'(b.m_dat >> 16) : 16'(b.m_dat);
      return b.m_sgn ? 32'($signed(hw)) : 32'(hw);
    end
    return b.m_dat;
  endfunction

  function automatic bit src_ok();
    if (b.w_sel == 2'b11) return 1'b0;
    if (b.w_sel == 2'b01)
      return b.m_sel inside {4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF, 4'h0};
    return 1'b1;
  endfunction

  function automatic logic [31:0] wb_val();
    if (b.w_sel == 2'b00) return b.w_alu;
    if (b.w_sel == 2'b10) return b.w_lnk;
    return load_val();
  endfunction

  function automatic logic [31:0] exp_rd(input int tid, input int a);
    if (sweep < NENT) return 32'h0;
    if (b.w_wre && b.gena && src_ok() && int'(b.w_tid) == tid && int'(b.w_rw) == a && a != 0)
      return wb_val();
    return mdl[tid][a];
  endfunction

  always @(posedge gclk or posedge grst) begin
    if (grst) begin
      sweep <= 0;
      merr  <= 1'b0;
      for (int t = 0; t < 2; t++)
        for (int r = 0; r < NREG; r++) mdl[t][r] <= 32'h0;
    end else if (sweep < NENT) begin
      sweep <= sweep + 1;
    end else if (b.w_wre && b.gena) begin
      if (!src_ok()) merr <= 1'b1;
      else if (b.w_rw != 0) mdl[b.w_tid][b.w_rw] <= wb_val();
    end
  end

  // Every falling edge: all outputs against the model.
  always @(negedge gclk) begin
    chk("model_da",  b.d_da, exp_rd(int'(b.d_tid), int'(b.d_ra)));
    chk("model_db",  b.d_db, exp_rd(int'(b.d_tid), int'(b.d_rb)));
    chk("model_dd",  b.d_dd, exp_rd(int'(b.d_tid), int'(b.d_rd)));
    chk("model_rdy", 32'(b.g_rdy), 32'(sweep == NENT));
    chk("model_err", 32'(b.g_err), 32'(merr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle();
    b.w_wre = 1'b0; b.gena = 1'b1; b.w_sel = 2'b00;
  endtask

  task automatic wait_rdy(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (b.g_rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic wr(input int tid, input int r, input logic [1:0] sel, input logic [31:0] v);
    b.w_tid = TW'(tid); b.w_rw = AW'(r); b.w_sel = sel;
    b.w_alu = v; b.w_lnk = v; b.w_wre = 1'b1; b.gena = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd_lit(input string name, input int tid, input int r, input logic [31:0] exp);
    b.d_tid = TW'(tid); b.d_ra = AW'(r); b.d_rb = AW'(r); b.d_rd = AW'(r);
    @(negedge gclk);
    chk(name, b.d_da, exp);
    tick();
  endtask

  task automatic load_case(input int r, input logic [3:0] sel, input logic sgn,
                           input logic [31:0] exp);
    b.w_tid = 1'b0; b.w_rw = AW'(r); b.w_sel = 2'b01; b.m_dat = 32'h80F0_1234;
    b.m_sel = sel; b.m_sgn = sgn; b.w_wre = 1'b1; b.gena = 1'b1;
    b.d_tid = 1'b0; b.d_ra = AW'(r);
    @(negedge gclk);
    chk("load_bypass", b.d_da, exp);
    tick();
    idle();
    rd_lit("load_stored", 0, r, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    b.gena = 1'b0; b.d_tid = '0; b.d_ra = '0; b.d_rb = '0; b.d_rd = '0;
    b.w_tid = '0; b.w_rw = '0; b.w_wre = 1'b0; b.w_sel = 2'b00;
    b.w_alu = '0; b.w_lnk = '0; b.m_dat = '0; b.m_sel = 4'h0; b.m_sgn = 1'b0;

    repeat (3) tick();
    @(negedge gclk);
    chk("reset_rdy", 32'(b.g_rdy), 32'h0);
    chk("reset_err", 32'(b.g_err), 32'h0);

    // Sweep ignores gena/w_wre: hold an enabled write request throughout.
    b.gena = 1'b1; b.w_wre = 1'b1; b.w_rw = AW'(3); b.w_alu = 32'h5555_AAAA;
    tick();
    grst = 1'b0;
    wait_rdy("sweep_len", 64);
    idle();

    // Restart mid-sweep at count 20.
    tick();
    grst = 1'b1;
    tick();
    grst = 1'b0;
    repeat (20) tick();
    chk("pulse_rdy_low", 32'(b.g_rdy), 32'h0);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    wait_rdy("restart_len", 64);

    // Every entry of both banks reads zero.
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < NREG; r += 3) begin
        b.d_tid = TW'(t); b.d_ra = AW'(r); b.d_rb = AW'(r + 1); b.d_rd = AW'(r + 2);
        tick();
      end

    // Bank separation.
    wr(1, 5, 2'b00, 32'hDEAD_BEEF);
    rd_lit("tid1_r5", 1, 5, 32'hDEAD_BEEF);
    rd_lit("tid0_r5", 0, 5, 32'h0);

    // Same-cycle bypass, then gena=0 suppressing bypass and write.
    wr(0, 7, 2'b00, 32'h1111_1111);
    b.d_tid = 1'b0; b.d_ra = AW'(7); b.d_rb = AW'(7); b.d_rd = AW'(7);
    b.w_tid = 1'b0; b.w_rw = AW'(7); b.w_sel = 2'b00; b.w_alu = 32'h2222_2222;
    b.w_wre = 1'b1; b.gena = 1'b1;
    @(negedge gclk);
    chk("bypass_a", b.d_da, 32'h2222_2222);
    chk("bypass_b", b.d_db, 32'h2222_2222);
    tick();
    b.w_alu = 32'h3333_3333; b.gena = 1'b0;
    @(negedge gclk);
    chk("gena0_a", b.d_da, 32'h2222_2222);
    tick();
    idle();
    rd_lit("gena0_nowr", 0, 7, 32'h2222_2222);

    // Load sizer.
    load_case(8,  4'h8, 1'b1, 32'hFFFF_FF80);
    load_case(9,  4'hC, 1'b0, 32'h0000_80F0);
    load_case(10, 4'h1, 1'b1, 32'h0000_0034);
    load_case(11, 4'h4, 1'b1, 32'hFFFF_FFF0);
    load_case(12, 4'h2, 1'b0, 32'h0000_0012);
    load_case(13, 4'h3, 1'b1, 32'h0000_1234);
    load_case(14, 4'hC, 1'b1, 32'hFFFF_80F0);
    load_case(15, 4'hF, 1'b1, 32'h80F0_1234);
    load_case(16, 4'h0, 1'b0, 32'h80F0_1234);

    // Link source.
    wr(1, 20, 2'b10, 32'hCAFE_0000);
    rd_lit("link", 1, 20, 32'hCAFE_0000);

    // r0 never written and never bypassed.
    b.d_tid = 1'b0; b.d_ra = '0;
    b.w_tid = 1'b0; b.w_rw = '0; b.w_sel = 2'b00; b.w_alu = 32'h5; b.w_wre = 1'b1;
    @(negedge gclk);
    chk("r0_bypass", b.d_da, 32'h0);
    tick();
    idle();
    rd_lit("r0_read", 0, 0, 32'h0);

    // Illegal source while gena=0 is ignored.
    b.w_rw = AW'(21); b.w_sel = 2'b11; b.w_wre = 1'b1; b.gena = 1'b0;
    tick();
    idle();
    chk("err_gena0", 32'(b.g_err), 32'h0);

    // Illegal source discarded and sticky error.
    b.w_tid = 1'b0; b.w_rw = AW'(21); b.w_sel = 2'b11; b.w_alu = 32'h7777_7777;
    b.w_wre = 1'b1; b.gena = 1'b1; b.d_ra = AW'(21);
    @(negedge gclk);
    chk("illegal_nobyp", b.d_da, 32'h0);
    tick();
    idle();
    chk("err_set", 32'(b.g_err), 32'h1);
    rd_lit("illegal_nowr", 0, 21, 32'h0);
    wr(0, 22, 2'b00, 32'h0000_0022);
    chk("err_sticky", 32'(b.g_err), 32'h1);

    grst = 1'b1;
    tick();
    chk("err_clr", 32'(b.g_err), 32'h0);
    grst = 1'b0;
    wait_rdy("sweep3_len", 64);

    // Illegal load lane select.
    b.w_tid = 1'b1; b.w_rw = AW'(9); b.w_sel = 2'b01; b.m_sel = 4'h5;
    b.w_wre = 1'b1; b.gena = 1'b1;
    tick();
    idle();
    chk("err_msel", 32'(b.g_err), 32'h1);
    rd_lit("msel_nowr", 1, 9, 32'h0);
    rd_lit("tid1_r5_cleared", 1, 5, 32'h0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
